// File: rtl/apu_sfx_pkg.sv
// Shared constants for the APU sound-effect player: sound IDs, FSM states and
// per-sound frame-sequencing tables.
package apu_sfx_pkg;

  typedef enum logic [1:0] {
    SND_NONE = 2'b00,
    SND_EAT  = 2'b01,
    SND_HIT  = 2'b10,
    SND_DIE  = 2'b11
  } sound_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } sfx_state_t;

  localparam int IDX_W = 5;

  localparam int EAT_LEN   = 8;
  localparam int EAT_START = 400;
  localparam int EAT_STEP  = 24;

  localparam int HIT_LEN   = 6;
  localparam int HIT_START = 600;
  localparam int HIT_ALT   = 900;

  localparam int DIE_LEN   = 24;
  localparam int DIE_START = 300;
  localparam int DIE_STEP  = 32;

  function automatic int sound_len(input sound_id_t id);
    case (id)
      SND_EAT: return EAT_LEN;
      SND_HIT: return HIT_LEN;
      SND_DIE: return DIE_LEN;
      default: return 1;
    endcase
  endfunction

  function automatic int sound_start(input sound_id_t id);
    case (id)
      SND_EAT: return EAT_START;
      SND_HIT: return HIT_START;
      SND_DIE: return DIE_START;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/apu_tone_gen.sv
// Square-wave tone generator: counts cycles and toggles the phase every
// half_period cycles while enabled.
module apu_tone_gen #(
  parameter int HP_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            restart,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            phase
);

  logic [HP_W-1:0] count;
  logic            wrap;

  // Widened compare avoids underflow of half_period-1 and still fires when the
  // half-period shrinks below the running count.
  assign wrap = ({1'b0, count} + (HP_W+1)'(1)) >= {1'b0, half_period};

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      count <= '0;
      phase <= 1'b0;
    end else if (enable) begin
      if (wrap) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/apu_sfx_player.sv
// Priority-arbitrated sound-effect player driving a 1-bit square-wave pin.
// Optional feature macro: APU_SFX_DECAY_EN (per-frame volume decay with PWM gating).
module apu_sfx_player
  import apu_sfx_pkg::*;
#(
  parameter int HP_W = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       eat_sound,
  input  logic       hit_sound,
  input  logic       die_sound,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] active_id
);

  sfx_state_t       state, state_next;
  sound_id_t        cur_id, win_id;
  logic [2:0]       req, prev_req, edges;
  logic [IDX_W-1:0] frame_idx, last_idx;
  logic [HP_W-1:0]  half_period, hp_next;
  logic             accept, start, advance, finish;
  logic             phase;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input int b);
    logic [HP_W:0] diff;
    diff = {1'b0, a} - (HP_W+1)'(b);
    return diff[HP_W] ? '0 : diff[HP_W-1:0];
  endfunction

  function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] a, input int b);
    logic [HP_W:0] sum;
    sum = {1'b0, a} + (HP_W+1)'(b);
    return sum[HP_W] ? '1 : sum[HP_W-1:0];
  endfunction

  assign req   = {die_sound, hit_sound, eat_sound};
  assign edges = req & ~prev_req;

  // IDs are numbered by priority, so a plain compare decides preemption.
  always_comb begin
    win_id = SND_NONE;
    if (edges[2])      win_id = SND_DIE;
    else if (edges[1]) win_id = SND_HIT;
    else if (edges[0]) win_id = SND_EAT;
  end

  assign accept   = (win_id != SND_NONE) && ((state == ST_IDLE) || (win_id >= cur_id));
  assign last_idx = IDX_W'(sound_len(cur_id) - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A new start always beats a coincident frame_end, including the final one.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_PLAY;
          start      = 1'b1;
        end
      end
      ST_PLAY: begin
        if (accept) begin
          start = 1'b1;
        end else if (frame_end) begin
          if (frame_idx == last_idx) begin
            state_next = ST_IDLE;
            finish     = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hp_next = half_period;
    case (cur_id)
      SND_EAT: hp_next = sat_sub(half_period, EAT_STEP);
      SND_HIT: hp_next = frame_idx[0] ? HP_W'(HIT_START) : HP_W'(HIT_ALT);
      SND_DIE: hp_next = sat_add(half_period, DIE_STEP);
      default: hp_next = half_period;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_req    <= '0;
      cur_id      <= SND_NONE;
      frame_idx   <= '0;
      half_period <= '0;
    end else begin
      prev_req <= req;
      if (start) begin
        cur_id      <= win_id;
        frame_idx   <= '0;
        half_period <= HP_W'(sound_start(win_id));
      end else if (finish) begin
        cur_id <= SND_NONE;
      end else if (advance) begin
        frame_idx   <= frame_idx + IDX_W'(1);
        half_period <= hp_next;
      end
    end
  end

  apu_tone_gen #(.HP_W(HP_W)) u_tone (
    .clk         (clk),
    .reset       (reset),
    .restart     (start),
    .enable      (state == ST_PLAY),
    .half_period (half_period),
    .phase       (phase)
  );

  assign busy      = (state == ST_PLAY);
  assign active_id = cur_id;

`ifdef APU_SFX_DECAY_EN
  logic [3:0] volume, pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      volume  <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (start)                        volume <= 4'd15;
      else if (advance && volume > 4'd1) volume <= volume - 4'd1;
    end
  end

  assign audio_out = busy & phase & (pwm_cnt < volume);
`else
  assign audio_out = busy & phase;
`endif

endmodule

// File: tb/tb_apu_sfx_player.sv
// Self-checking bench for apu_sfx_player: vector table for arbitration plus
// directed multi-frame sequences measuring tone half-periods.
module tb_apu_sfx_player;

  logic       clk = 1'b0;
  logic       reset, frame_end, eat_sound, hit_sound, die_sound;
  logic       audio_out, busy;
  logic [1:0] active_id;
  logic       sq;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic       rst, eat, hit, die, fe;
    logic       exp_busy;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[16];

  apu_sfx_player #(.HP_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_end (frame_end),
    .eat_sound (eat_sound),
    .hit_sound (hit_sound),
    .die_sound (die_sound),
    .audio_out (audio_out),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  // With decay the pin is PWM-chopped, so tone timing is taken from the raw square.
`ifdef APU_SFX_DECAY_EN
  assign sq = dut.u_tone.phase & busy;
`else
  assign sq = audio_out;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic h, input logic d, input logic f);
    reset     = r;
    eat_sound = e;
    hit_sound = h;
    die_sound = d;
    frame_end = f;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic frames(input int count, input int gap);
    repeat (count) begin
      repeat (gap) tick();
      pulse_frame();
    end
  endtask

  // Cycles from a (re)start until the square first goes high; -1 on timeout.
  task automatic measure_first(output int n);
    n = 0;
    while (sq == 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    if (sq == 1'b0) n = -1;
  endtask

  // Skips one (possibly partial) half-period, then times a full one.
  task automatic measure_period(output int n);
    logic s0;
    int   k;
    s0 = sq;
    k  = 0;
    while (sq == s0 && k < 5000) begin
      tick();
      k++;
    end
    if (sq == s0) begin
      n = -1;
      return;
    end
    s0 = sq;
    n  = 0;
    while (sq == s0 && n < 5000) begin
      tick();
      n++;
    end
    if (sq == s0) n = -1;
  endtask

  initial begin
    #5_000_000;
    errors++;
    checks++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n;
    int k;

    reset = 1'b1; frame_end = 1'b0;
    eat_sound = 1'b0; hit_sound = 1'b0; die_sound = 1'b0;
    tick();
    tick();

    //          rst eat hit die fe  busy id
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 2'd0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 2'd0};
    vecs[2]  = '{0, 1, 0, 0, 0, 1, 2'd1};
    vecs[3]  = '{0, 1, 0, 0, 0, 1, 2'd1};
    vecs[4]  = '{0, 1, 1, 0, 0, 1, 2'd2};
    vecs[5]  = '{0, 0, 1, 0, 1, 1, 2'd2};
    vecs[6]  = '{0, 1, 1, 0, 0, 1, 2'd2};
    vecs[7]  = '{0, 0, 0, 1, 0, 1, 2'd3};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 2'd3};
    vecs[9]  = '{0, 0, 1, 0, 0, 1, 2'd3};
    vecs[10] = '{0, 0, 0, 1, 0, 1, 2'd3};
    vecs[11] = '{1, 0, 0, 1, 0, 0, 2'd0};
    vecs[12] = '{0, 0, 0, 1, 0, 1, 2'd3};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 2'd0};
    vecs[14] = '{0, 1, 1, 1, 0, 1, 2'd3};
    vecs[15] = '{1, 0, 0, 0, 0, 0, 2'd0};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].eat, vecs[i].hit, vecs[i].die, vecs[i].fe);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_id", i), 32'(active_id), 32'(vecs[i].exp_id));
      checkOutput($sformatf("vec%0d_audio", i), 32'(audio_out), 32'd0);
    end

    // Eat chirp held high through the whole sound: 8 frames, no retrigger.
    do_reset();
    eat_sound = 1'b1;
    tick();
    checkOutput("eat_busy", 32'(busy), 32'd1);
    checkOutput("eat_id", 32'(active_id), 32'd1);
    measure_first(n);
    checkOutput("eat_first_half", 32'(n), 32'd400);
    repeat (100) tick();
    pulse_frame();
    measure_period(n);
    checkOutput("eat_frame1_half", 32'(n), 32'd376);
    frames(6, 20);
    checkOutput("eat_busy_after7", 32'(busy), 32'd1);
    checkOutput("eat_id_after7", 32'(active_id), 32'd1);
    pulse_frame();
    checkOutput("eat_idle_busy", 32'(busy), 32'd0);
    checkOutput("eat_idle_id", 32'(active_id), 32'd0);
    checkOutput("eat_idle_audio", 32'(audio_out), 32'd0);
    repeat (50) tick();
    checkOutput("eat_no_retrigger", 32'(busy), 32'd0);
    eat_sound = 1'b0;

    // Hit preempts eat at frame 3 and plays its own 6 frames.
    do_reset();
    eat_sound = 1'b1;
    tick();
    eat_sound = 1'b0;
    frames(3, 20);
    hit_sound = 1'b1;
    tick();
    checkOutput("hit_preempt_id", 32'(active_id), 32'd2);
    measure_first(n);
    checkOutput("hit_first_half", 32'(n), 32'd600);
    measure_period(n);
    checkOutput("hit_frame0_half", 32'(n), 32'd600);
    pulse_frame();
    measure_period(n);
    checkOutput("hit_frame1_half", 32'(n), 32'd900);
    frames(4, 20);
    checkOutput("hit_busy_after5", 32'(busy), 32'd1);
    checkOutput("hit_id_after5", 32'(active_id), 32'd2);
    pulse_frame();
    checkOutput("hit_idle_busy", 32'(busy), 32'd0);
    checkOutput("hit_idle_audio", 32'(audio_out), 32'd0);
    hit_sound = 1'b0;

    // Die ignores a later eat edge and ends on a 1036-cycle half-period.
    do_reset();
    die_sound = 1'b1;
    tick();
    checkOutput("die_id", 32'(active_id), 32'd3);
    frames(2, 20);
    eat_sound = 1'b1;
    tick();
    checkOutput("die_ignores_eat_id", 32'(active_id), 32'd3);
    checkOutput("die_ignores_eat_busy", 32'(busy), 32'd1);
    frames(21, 20);
    measure_period(n);
    checkOutput("die_last_half", 32'(n), 32'd1036);
    checkOutput("die_id_last", 32'(active_id), 32'd3);
    pulse_frame();
    checkOutput("die_idle_busy", 32'(busy), 32'd0);
    die_sound = 1'b0;
    eat_sound = 1'b0;

    // Start coincident with frame_end: that frame_end is not counted.
    do_reset();
    eat_sound = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checkOutput("coinc_busy", 32'(busy), 32'd1);
    frames(7, 10);
    checkOutput("coinc_busy_after7", 32'(busy), 32'd1);
    hit_sound = 1'b1;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    checkOutput("lastframe_edge_busy", 32'(busy), 32'd1);
    checkOutput("lastframe_edge_id", 32'(active_id), 32'd2);
    eat_sound = 1'b0;
    hit_sound = 1'b0;

    // Reset while die is sounding, then a fresh die edge.
    do_reset();
    die_sound = 1'b1;
    tick();
    frames(2, 20);
    k = 0;
    while (sq == 1'b0 && k < 2000) begin
      tick();
      k++;
    end
    checkOutput("die_square_high", 32'(sq), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rst_audio", 32'(audio_out), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_id", 32'(active_id), 32'd0);
    reset = 1'b0;
    die_sound = 1'b0;
    tick();
    die_sound = 1'b1;
    tick();
    checkOutput("die_restart_id", 32'(active_id), 32'd3);
`ifdef APU_SFX_DECAY_EN
    checkOutput("decay_vol_start", 32'(dut.volume), 32'd15);
`endif
    measure_first(n);
    checkOutput("die_restart_first_half", 32'(n), 32'd300);
`ifdef APU_SFX_DECAY_EN
    pulse_frame();
    checkOutput("decay_vol_frame1", 32'(dut.volume), 32'd14);
`endif
    die_sound = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
